// File: rtl/ddr3_ctrl_pkg.sv
// Shared constants for the DDR3 app-port command sequencer: app command codes,
// FSM state encoding, grant encoding and burst-mode helpers.
package ddr3_ctrl_pkg;

  localparam logic [2:0] CMD_WRITE = 3'b000;
  localparam logic [2:0] CMD_READ  = 3'b001;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_WR   = 2'd1;
  localparam state_t ST_RD   = 2'd2;

  localparam logic GRANT_RD = 1'b0;
  localparam logic GRANT_WR = 1'b1;

  // BURST_MODE is the ASCII character "4" or "8".
  function automatic int burst_beats(input logic [7:0] mode);
    return (mode == "8") ? 2 : 1;
  endfunction

  function automatic int burst_addr_shift(input logic [7:0] mode);
    return (mode == "8") ? 3 : 2;
  endfunction

endpackage

// File: rtl/ddr3_rd_tracker.sv
// Outstanding-read counter (saturating, underflow-guarded) and registered read-return path.
// With DDR3_CTRL_STATS_EN defined, also reports a sticky return-underflow flag.
module ddr3_rd_tracker
  import ddr3_ctrl_pkg::*;
#(
  parameter int APP_DATA_WIDTH = 64,
  parameter int MAX_RD_OUT     = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rd_cmd_accept,
  input  logic [APP_DATA_WIDTH-1:0] app_rd_data,
  input  logic                      app_rd_data_valid,
  input  logic                      app_rd_data_end,
  output logic [APP_DATA_WIDTH-1:0] rd_data,
  output logic                      rd_data_valid,
  output logic                      rd_data_last,
`ifdef DDR3_CTRL_STATS_EN
  output logic                      rd_underflow,
`endif
  output logic [7:0]                rd_outstanding
);

  localparam logic [7:0] MAX_CNT = 8'(MAX_RD_OUT);

  logic                      ret_last;
  logic [7:0]                cnt_reg;
  logic [7:0]                cnt_next;
  logic [APP_DATA_WIDTH-1:0] data_reg;
  logic                      valid_reg;
  logic                      last_reg;

  assign ret_last = app_rd_data_valid && app_rd_data_end;

  // A return with nothing outstanding is spurious: it never cancels a new accept.
  always_comb begin
    cnt_next = cnt_reg;
    case ({rd_cmd_accept, ret_last})
      2'b10:   if (cnt_reg < MAX_CNT) cnt_next = cnt_reg + 8'd1;
      2'b01:   if (cnt_reg != 8'd0) cnt_next = cnt_reg - 8'd1;
      2'b11:   if (cnt_reg == 8'd0) cnt_next = 8'd1;
      default: cnt_next = cnt_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg   <= 8'd0;
      data_reg  <= '0;
      valid_reg <= 1'b0;
      last_reg  <= 1'b0;
    end else begin
      cnt_reg   <= cnt_next;
      data_reg  <= app_rd_data;
      valid_reg <= app_rd_data_valid;
      last_reg  <= ret_last;
    end
  end

  assign rd_outstanding = cnt_reg;
  assign rd_data        = data_reg;
  assign rd_data_valid  = valid_reg;
  assign rd_data_last   = last_reg;

`ifdef DDR3_CTRL_STATS_EN
  logic underflow_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      underflow_reg <= 1'b0;
    end else if (ret_last && cnt_reg == 8'd0) begin
      underflow_reg <= 1'b1;
    end
  end

  assign rd_underflow = underflow_reg;
`endif

endmodule

// File: rtl/ddr3_app_cmd_ctrl.sv
// Round-robin write/read request sequencer onto a MIG-style DDR3 app port (BL4/BL8).
// Optional command counters and read-underflow flag under DDR3_CTRL_STATS_EN.
module ddr3_app_cmd_ctrl
  import ddr3_ctrl_pkg::*;
#(
  parameter int         ADDR_WIDTH     = 28,
  parameter int         USER_ADDR_W    = 16,
  parameter int         APP_DATA_WIDTH = 64,
  parameter int         APP_MASK_WIDTH = 8,
  parameter logic [7:0] BURST_MODE     = "4",
  parameter int         MAX_RD_OUT     = 8
) (
  input  logic                                              clk,
  input  logic                                              rst,
  input  logic                                              init_calib_complete,
  input  logic                                              wr_req_valid,
  output logic                                              wr_req_ready,
  input  logic [USER_ADDR_W-1:0]                            wr_req_addr,
  input  logic [APP_DATA_WIDTH*burst_beats(BURST_MODE)-1:0] wr_req_data,
  input  logic [APP_MASK_WIDTH*burst_beats(BURST_MODE)-1:0] wr_req_mask,
  input  logic                                              rd_req_valid,
  output logic                                              rd_req_ready,
  input  logic [USER_ADDR_W-1:0]                            rd_req_addr,
  output logic                                              app_en,
  output logic [2:0]                                        app_cmd,
  output logic [ADDR_WIDTH-1:0]                             app_addr,
  output logic [APP_DATA_WIDTH-1:0]                         app_wdf_data,
  output logic                                              app_wdf_wren,
  output logic                                              app_wdf_end,
  output logic [APP_MASK_WIDTH-1:0]                         app_wdf_mask,
  output logic                                              app_burst,
  input  logic                                              app_rdy,
  input  logic                                              app_wdf_rdy,
  input  logic [APP_DATA_WIDTH-1:0]                         app_rd_data,
  input  logic                                              app_rd_data_valid,
  input  logic                                              app_rd_data_end,
  output logic [APP_DATA_WIDTH-1:0]                         rd_data,
  output logic                                              rd_data_valid,
  output logic                                              rd_data_last,
  output logic [7:0]                                        rd_outstanding,
`ifdef DDR3_CTRL_STATS_EN
  output logic [31:0]                                       wr_cmd_cnt,
  output logic [31:0]                                       rd_cmd_cnt,
  output logic                                              rd_underflow,
`endif
  output logic                                              busy
);

  localparam int   BEATS      = burst_beats(BURST_MODE);
  localparam int   ADDR_SHIFT = burst_addr_shift(BURST_MODE);
  localparam int   DATA_W     = APP_DATA_WIDTH * BEATS;
  localparam int   MASK_W     = APP_MASK_WIDTH * BEATS;
  localparam logic LAST_BEAT  = 1'(BEATS - 1);

  state_t              state_reg;
  logic                last_grant_reg;
  logic [2:0]          cmd_reg;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [DATA_W-1:0]   data_reg;
  logic [MASK_W-1:0]   mask_reg;
  logic                cmd_done_reg;
  logic                data_done_reg;
  logic                beat_idx_reg;

  logic                idle;
  logic                wr_elig;
  logic                rd_elig;
  logic                wr_grant;
  logic                rd_grant;
  logic                cmd_accept;
  logic                wdf_fire;
  logic                cmd_done_now;
  logic                data_done_now;
  logic [ADDR_WIDTH-1:0] wr_app_addr;
  logic [ADDR_WIDTH-1:0] rd_app_addr;

  logic [APP_DATA_WIDTH-1:0] beat_data [BEATS];
  logic [APP_MASK_WIDTH-1:0] beat_mask [BEATS];

  // Ready is gated by rst so nothing is granted while reset is held.
  assign idle     = (state_reg == ST_IDLE) && !rst;
  assign wr_elig  = init_calib_complete && wr_req_valid;
  assign rd_elig  = init_calib_complete && rd_req_valid && (rd_outstanding < 8'(MAX_RD_OUT));
  assign wr_grant = wr_elig && (!rd_elig || last_grant_reg == GRANT_RD);
  assign rd_grant = rd_elig && (!wr_elig || last_grant_reg == GRANT_WR);

  assign wr_req_ready = idle && wr_grant;
  assign rd_req_ready = idle && rd_grant;

  assign wr_app_addr = ADDR_WIDTH'({wr_req_addr, {ADDR_SHIFT{1'b0}}});
  assign rd_app_addr = ADDR_WIDTH'({rd_req_addr, {ADDR_SHIFT{1'b0}}});

  assign app_en       = (state_reg == ST_RD) || (state_reg == ST_WR && !cmd_done_reg);
  assign app_cmd      = cmd_reg;
  assign app_addr     = addr_reg;
  assign app_burst    = 1'b0;
  assign app_wdf_wren = (state_reg == ST_WR) && !data_done_reg;
  assign app_wdf_end  = app_wdf_wren && (beat_idx_reg == LAST_BEAT);

  for (genvar gi = 0; gi < BEATS; gi++) begin : g_beat
    assign beat_data[gi] = data_reg[gi*APP_DATA_WIDTH +: APP_DATA_WIDTH];
    assign beat_mask[gi] = mask_reg[gi*APP_MASK_WIDTH +: APP_MASK_WIDTH];
  end

  if (BEATS == 1) begin : g_bl4
    assign app_wdf_data = beat_data[0];
    assign app_wdf_mask = beat_mask[0];
  end else begin : g_bl8
    assign app_wdf_data = beat_data[beat_idx_reg];
    assign app_wdf_mask = beat_mask[beat_idx_reg];
  end

  // Command and data channels progress independently; WR ends when both are done.
  assign cmd_accept    = app_en && app_rdy;
  assign wdf_fire      = app_wdf_wren && app_wdf_rdy;
  assign cmd_done_now  = cmd_done_reg || cmd_accept;
  assign data_done_now = data_done_reg || (wdf_fire && app_wdf_end);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      last_grant_reg <= GRANT_RD;
      cmd_reg        <= 3'b000;
      addr_reg       <= '0;
      data_reg       <= '0;
      mask_reg       <= '0;
      cmd_done_reg   <= 1'b0;
      data_done_reg  <= 1'b0;
      beat_idx_reg   <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          cmd_done_reg  <= 1'b0;
          data_done_reg <= 1'b0;
          beat_idx_reg  <= 1'b0;
          if (wr_req_ready) begin
            state_reg      <= ST_WR;
            last_grant_reg <= GRANT_WR;
            cmd_reg        <= CMD_WRITE;
            addr_reg       <= wr_app_addr;
            data_reg       <= wr_req_data;
            mask_reg       <= wr_req_mask;
          end else if (rd_req_ready) begin
            state_reg      <= ST_RD;
            last_grant_reg <= GRANT_RD;
            cmd_reg        <= CMD_READ;
            addr_reg       <= rd_app_addr;
          end
        end
        ST_WR: begin
          cmd_done_reg <= cmd_done_now;
          if (wdf_fire) begin
            if (app_wdf_end) begin
              data_done_reg <= 1'b1;
            end else begin
              beat_idx_reg <= beat_idx_reg + 1'b1;
            end
          end
          if (cmd_done_now && data_done_now) begin
            state_reg <= ST_IDLE;
          end
        end
        ST_RD: begin
          if (app_rdy) begin
            state_reg <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign busy = (state_reg != ST_IDLE);

  ddr3_rd_tracker #(
    .APP_DATA_WIDTH (APP_DATA_WIDTH),
    .MAX_RD_OUT     (MAX_RD_OUT)
  ) u_rd_tracker (
    .clk               (clk),
    .rst               (rst),
    .rd_cmd_accept     (cmd_accept && cmd_reg == CMD_READ),
    .app_rd_data       (app_rd_data),
    .app_rd_data_valid (app_rd_data_valid),
    .app_rd_data_end   (app_rd_data_end),
    .rd_data           (rd_data),
    .rd_data_valid     (rd_data_valid),
    .rd_data_last      (rd_data_last),
`ifdef DDR3_CTRL_STATS_EN
    .rd_underflow      (rd_underflow),
`endif
    .rd_outstanding    (rd_outstanding)
  );

`ifdef DDR3_CTRL_STATS_EN
  logic [31:0] wr_cmd_cnt_reg;
  logic [31:0] rd_cmd_cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_cmd_cnt_reg <= 32'd0;
      rd_cmd_cnt_reg <= 32'd0;
    end else if (cmd_accept) begin
      if (cmd_reg == CMD_WRITE) wr_cmd_cnt_reg <= wr_cmd_cnt_reg + 32'd1;
      else                      rd_cmd_cnt_reg <= rd_cmd_cnt_reg + 32'd1;
    end
  end

  assign wr_cmd_cnt = wr_cmd_cnt_reg;
  assign rd_cmd_cnt = rd_cmd_cnt_reg;
`endif

endmodule

// File: tb/tb_ddr3_app_cmd_ctrl.sv
// Directed bench: dut_a is BL4/MAX_RD_OUT=8, dut_b is BL8/MAX_RD_OUT=2; both share stimulus.
module tb_ddr3_app_cmd_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         init_calib_complete;
  logic         wr_req_valid;
  logic [15:0]  wr_req_addr;
  logic [127:0] wr_req_data;
  logic [15:0]  wr_req_mask;
  logic         rd_req_valid;
  logic [15:0]  rd_req_addr;
  logic         app_rdy;
  logic         app_wdf_rdy;
  logic [63:0]  app_rd_data;
  logic         app_rd_data_valid;
  logic         app_rd_data_end;

  logic a_wr_req_ready, a_rd_req_ready, a_app_en, a_app_wdf_wren, a_app_wdf_end, a_app_burst;
  logic a_rd_data_valid, a_rd_data_last, a_busy;
  logic [2:0] a_app_cmd;
  logic [27:0] a_app_addr;
  logic [63:0] a_app_wdf_data, a_rd_data;
  logic [7:0] a_app_wdf_mask, a_rd_outstanding;

  logic b_wr_req_ready, b_rd_req_ready, b_app_en, b_app_wdf_wren, b_app_wdf_end, b_app_burst;
  logic b_rd_data_valid, b_rd_data_last, b_busy;
  logic [2:0] b_app_cmd;
  logic [27:0] b_app_addr;
  logic [63:0] b_app_wdf_data, b_rd_data;
  logic [7:0] b_app_wdf_mask, b_rd_outstanding;

`ifdef DDR3_CTRL_STATS_EN
  logic [31:0] a_wr_cmd_cnt, a_rd_cmd_cnt, b_wr_cmd_cnt, b_rd_cmd_cnt;
  logic a_rd_underflow, b_rd_underflow;
`endif

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ddr3_app_cmd_ctrl #(
    .BURST_MODE ("4"),
    .MAX_RD_OUT (8)
  ) dut_a (
    .clk (clk), .rst (rst), .init_calib_complete (init_calib_complete),
    .wr_req_valid (wr_req_valid), .wr_req_ready (a_wr_req_ready), .wr_req_addr (wr_req_addr),
    .wr_req_data (wr_req_data[63:0]), .wr_req_mask (wr_req_mask[7:0]),
    .rd_req_valid (rd_req_valid), .rd_req_ready (a_rd_req_ready), .rd_req_addr (rd_req_addr),
    .app_en (a_app_en), .app_cmd (a_app_cmd), .app_addr (a_app_addr),
    .app_wdf_data (a_app_wdf_data), .app_wdf_wren (a_app_wdf_wren), .app_wdf_end (a_app_wdf_end),
    .app_wdf_mask (a_app_wdf_mask), .app_burst (a_app_burst),
    .app_rdy (app_rdy), .app_wdf_rdy (app_wdf_rdy), .app_rd_data (app_rd_data),
    .app_rd_data_valid (app_rd_data_valid), .app_rd_data_end (app_rd_data_end),
    .rd_data (a_rd_data), .rd_data_valid (a_rd_data_valid), .rd_data_last (a_rd_data_last),
    .rd_outstanding (a_rd_outstanding),
`ifdef DDR3_CTRL_STATS_EN
    .wr_cmd_cnt (a_wr_cmd_cnt), .rd_cmd_cnt (a_rd_cmd_cnt), .rd_underflow (a_rd_underflow),
`endif
    .busy (a_busy)
  );

  ddr3_app_cmd_ctrl #(
    .BURST_MODE ("8"),
    .MAX_RD_OUT (2)
  ) dut_b (
    .clk (clk), .rst (rst), .init_calib_complete (init_calib_complete),
    .wr_req_valid (wr_req_valid), .wr_req_ready (b_wr_req_ready), .wr_req_addr (wr_req_addr),
    .wr_req_data (wr_req_data), .wr_req_mask (wr_req_mask),
    .rd_req_valid (rd_req_valid), .rd_req_ready (b_rd_req_ready), .rd_req_addr (rd_req_addr),
    .app_en (b_app_en), .app_cmd (b_app_cmd), .app_addr (b_app_addr),
    .app_wdf_data (b_app_wdf_data), .app_wdf_wren (b_app_wdf_wren), .app_wdf_end (b_app_wdf_end),
    .app_wdf_mask (b_app_wdf_mask), .app_burst (b_app_burst),
    .app_rdy (app_rdy), .app_wdf_rdy (app_wdf_rdy), .app_rd_data (app_rd_data),
    .app_rd_data_valid (app_rd_data_valid), .app_rd_data_end (app_rd_data_end),
    .rd_data (b_rd_data), .rd_data_valid (b_rd_data_valid), .rd_data_last (b_rd_data_last),
    .rd_outstanding (b_rd_outstanding),
`ifdef DDR3_CTRL_STATS_EN
    .wr_cmd_cnt (b_wr_cmd_cnt), .rd_cmd_cnt (b_rd_cmd_cnt), .rd_underflow (b_rd_underflow),
`endif
    .busy (b_busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    init_calib_complete = 1'b0;
    wr_req_valid = 1'b0; wr_req_addr = '0; wr_req_data = '0; wr_req_mask = '0;
    rd_req_valid = 1'b0; rd_req_addr = '0;
    app_rdy = 1'b0; app_wdf_rdy = 1'b0;
    app_rd_data = '0; app_rd_data_valid = 1'b0; app_rd_data_end = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [255:0] a_all, b_all;
    do_reset();
    a_all = {a_wr_req_ready, a_rd_req_ready, a_app_en, a_app_cmd, a_app_addr, a_app_wdf_data,
             a_app_wdf_wren, a_app_wdf_end, a_app_wdf_mask, a_app_burst, a_rd_data,
             a_rd_data_valid, a_rd_data_last, a_rd_outstanding, a_busy};
    b_all = {b_wr_req_ready, b_rd_req_ready, b_app_en, b_app_cmd, b_app_addr, b_app_wdf_data,
             b_app_wdf_wren, b_app_wdf_end, b_app_wdf_mask, b_app_burst, b_rd_data,
             b_rd_data_valid, b_rd_data_last, b_rd_outstanding, b_busy};
    n_checks++; if (a_all !== '0) begin n_fail++; $display("FAIL reset_a_outputs: got %h want 0", a_all); end
    n_checks++; if (b_all !== '0) begin n_fail++; $display("FAIL reset_b_outputs: got %h want 0", b_all); end
    $display("test_reset: outputs checked after reset");
  endtask

  task automatic test_write_bl4();
    do_reset();
    init_calib_complete = 1'b1; app_rdy = 1'b1; app_wdf_rdy = 1'b1;
    wr_req_valid = 1'b1; wr_req_addr = 16'h0010;
    wr_req_data = {64'h0, 64'h1122_3344_5566_7788}; wr_req_mask = 16'h0003;
    #1;
    n_checks++; if (a_wr_req_ready !== 1'b1) begin n_fail++; $display("FAIL bl4_wr_ready: got %b want 1", a_wr_req_ready); end
    n_checks++; if (a_rd_req_ready !== 1'b0) begin n_fail++; $display("FAIL bl4_rd_ready: got %b want 0", a_rd_req_ready); end
    tick();
    wr_req_valid = 1'b0;
    n_checks++; if (a_app_en !== 1'b1) begin n_fail++; $display("FAIL bl4_app_en: got %b want 1", a_app_en); end
    n_checks++; if (a_app_cmd !== 3'b000) begin n_fail++; $display("FAIL bl4_app_cmd: got %b want 000", a_app_cmd); end
    n_checks++; if (a_app_addr !== 28'h40) begin n_fail++; $display("FAIL bl4_app_addr: got %h want 40", a_app_addr); end
    n_checks++; if (a_app_wdf_wren !== 1'b1 || a_app_wdf_end !== 1'b1) begin n_fail++; $display("FAIL bl4_wren_end: got %b%b want 11", a_app_wdf_wren, a_app_wdf_end); end
    n_checks++; if (a_app_wdf_data !== 64'h1122_3344_5566_7788) begin n_fail++; $display("FAIL bl4_wdf_data: got %h want 1122334455667788", a_app_wdf_data); end
    n_checks++; if (a_app_wdf_mask !== 8'h03) begin n_fail++; $display("FAIL bl4_wdf_mask: got %h want 03", a_app_wdf_mask); end
    n_checks++; if (a_busy !== 1'b1 || a_app_burst !== 1'b0) begin n_fail++; $display("FAIL bl4_busy_burst: got %b%b want 10", a_busy, a_app_burst); end
    tick();
    n_checks++; if (a_busy !== 1'b0 || a_app_en !== 1'b0) begin n_fail++; $display("FAIL bl4_back_idle: got busy=%b en=%b want 0 0", a_busy, a_app_en); end
    $display("test_write_bl4: write addr 0010 issued and completed");
  endtask

  task automatic test_write_bl8_stall();
    do_reset();
    init_calib_complete = 1'b1; app_rdy = 1'b0; app_wdf_rdy = 1'b1;
    wr_req_valid = 1'b1; wr_req_addr = 16'h0010;
    wr_req_data = {64'hAAAA_BBBB_CCCC_DDDD, 64'h0123_4567_89AB_CDEF}; wr_req_mask = 16'hF00F;
    #1;
    n_checks++; if (b_wr_req_ready !== 1'b1) begin n_fail++; $display("FAIL bl8_wr_ready: got %b want 1", b_wr_req_ready); end
    tick();
    n_checks++; if (b_app_en !== 1'b1 || b_app_addr !== 28'h80) begin n_fail++; $display("FAIL bl8_cmd: got en=%b addr=%h want 1 80", b_app_en, b_app_addr); end
    n_checks++; if (b_app_wdf_wren !== 1'b1 || b_app_wdf_end !== 1'b0) begin n_fail++; $display("FAIL bl8_beat0_end: got %b%b want 10", b_app_wdf_wren, b_app_wdf_end); end
    n_checks++; if (b_app_wdf_data !== 64'h0123_4567_89AB_CDEF || b_app_wdf_mask !== 8'h0F) begin n_fail++; $display("FAIL bl8_beat0_data: got %h/%h want 0123456789abcdef/0f", b_app_wdf_data, b_app_wdf_mask); end
    tick();
    n_checks++; if (b_app_wdf_wren !== 1'b1 || b_app_wdf_end !== 1'b1) begin n_fail++; $display("FAIL bl8_beat1_end: got %b%b want 11", b_app_wdf_wren, b_app_wdf_end); end
    n_checks++; if (b_app_wdf_data !== 64'hAAAA_BBBB_CCCC_DDDD || b_app_wdf_mask !== 8'hF0) begin n_fail++; $display("FAIL bl8_beat1_data: got %h/%h want aaaabbbbccccdddd/f0", b_app_wdf_data, b_app_wdf_mask); end
    tick();
    n_checks++; if (b_app_wdf_wren !== 1'b0) begin n_fail++; $display("FAIL bl8_data_done: got wren=%b want 0", b_app_wdf_wren); end
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (b_app_en !== 1'b1 || b_busy !== 1'b1 || b_wr_req_ready !== 1'b0) begin n_fail++; $display("FAIL bl8_hold_%0d: got en=%b busy=%b ready=%b want 1 1 0", i, b_app_en, b_busy, b_wr_req_ready); end
      if (i < 2) tick();
    end
    app_rdy = 1'b1;
    wr_req_valid = 1'b0;
    tick();
    n_checks++; if (b_busy !== 1'b0 || b_app_en !== 1'b0) begin n_fail++; $display("FAIL bl8_done: got busy=%b en=%b want 0 0", b_busy, b_app_en); end
    $display("test_write_bl8_stall: BL8 write with app_rdy stalled completed");
  endtask

  task automatic test_round_robin();
    int waited;
    logic [2:0] exp_cmd;
    logic [27:0] exp_addr;
    do_reset();
    init_calib_complete = 1'b1; app_rdy = 1'b1; app_wdf_rdy = 1'b1;
    wr_req_valid = 1'b1; wr_req_addr = 16'h0100;
    rd_req_valid = 1'b1; rd_req_addr = 16'h0200;
    for (int k = 0; k < 4; k++) begin
      waited = 0;
      while (a_app_en !== 1'b1 && waited < 10) begin
        tick();
        waited++;
      end
      exp_cmd  = (k % 2 == 0) ? 3'b000 : 3'b001;
      exp_addr = (k % 2 == 0) ? 28'h400 : 28'h800;
      n_checks++; if (a_app_en !== 1'b1) begin n_fail++; $display("FAIL rr_timeout_%0d: app_en=%b want 1 within 10 cycles", k, a_app_en); end
      n_checks++; if (a_app_cmd !== exp_cmd || a_app_addr !== exp_addr) begin n_fail++; $display("FAIL rr_cmd_%0d: got %b/%h want %b/%h", k, a_app_cmd, a_app_addr, exp_cmd, exp_addr); end
      $display("test_round_robin: command %0d cmd=%b addr=%h", k, a_app_cmd, a_app_addr);
      tick();
    end
    wr_req_valid = 1'b0; rd_req_valid = 1'b0;
    n_checks++; if (a_rd_outstanding !== 8'd2) begin n_fail++; $display("FAIL rr_outstanding: got %0d want 2", a_rd_outstanding); end
  endtask

  task automatic test_outstanding_limit();
    do_reset();
    init_calib_complete = 1'b1; app_rdy = 1'b1;
    rd_req_valid = 1'b1; rd_req_addr = 16'h0005;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_checks++; if (b_rd_req_ready !== 1'b1) begin n_fail++; $display("FAIL lim_ready_%0d: got %b want 1", i, b_rd_req_ready); end
      tick();
      n_checks++; if (b_app_addr !== 28'h28 || b_app_cmd !== 3'b001) begin n_fail++; $display("FAIL lim_cmd_%0d: got %h/%b want 28/001", i, b_app_addr, b_app_cmd); end
      tick();
    end
    #1;
    n_checks++; if (b_rd_req_ready !== 1'b0 || b_rd_outstanding !== 8'd2) begin n_fail++; $display("FAIL lim_full: got ready=%b cnt=%0d want 0 2", b_rd_req_ready, b_rd_outstanding); end
    app_rd_data_valid = 1'b1; app_rd_data_end = 1'b1;
    tick();
    app_rd_data_valid = 1'b0; app_rd_data_end = 1'b0;
    #1;
    n_checks++; if (b_rd_outstanding !== 8'd1 || b_rd_req_ready !== 1'b1) begin n_fail++; $display("FAIL lim_return: got cnt=%0d ready=%b want 1 1", b_rd_outstanding, b_rd_req_ready); end
    tick();
    app_rd_data_valid = 1'b1; app_rd_data_end = 1'b1;
    tick();
    app_rd_data_valid = 1'b0; app_rd_data_end = 1'b0; rd_req_valid = 1'b0;
    n_checks++; if (b_rd_outstanding !== 8'd1) begin n_fail++; $display("FAIL lim_simul: got cnt=%0d want 1", b_rd_outstanding); end
    $display("test_outstanding_limit: 3 reads, 2 returns, count=%0d", b_rd_outstanding);
  endtask

  task automatic test_read_return();
    do_reset();
    app_rd_data = 64'hDEAD_BEEF_0000_0001; app_rd_data_valid = 1'b1; app_rd_data_end = 1'b0;
    tick();
    app_rd_data = 64'hCAFE_F00D_0000_0002; app_rd_data_end = 1'b1;
    n_checks++; if (b_rd_data !== 64'hDEAD_BEEF_0000_0001 || b_rd_data_valid !== 1'b1 || b_rd_data_last !== 1'b0) begin n_fail++; $display("FAIL ret_beat0: got %h v=%b l=%b want deadbeef00000001 1 0", b_rd_data, b_rd_data_valid, b_rd_data_last); end
    tick();
    app_rd_data_valid = 1'b0; app_rd_data_end = 1'b0; app_rd_data = 64'h0;
    n_checks++; if (b_rd_data !== 64'hCAFE_F00D_0000_0002 || b_rd_data_valid !== 1'b1 || b_rd_data_last !== 1'b1) begin n_fail++; $display("FAIL ret_beat1: got %h v=%b l=%b want cafef00d00000002 1 1", b_rd_data, b_rd_data_valid, b_rd_data_last); end
    tick();
    n_checks++; if (b_rd_data_valid !== 1'b0 || b_rd_data_last !== 1'b0) begin n_fail++; $display("FAIL ret_idle: got v=%b l=%b want 0 0", b_rd_data_valid, b_rd_data_last); end
    n_checks++; if (b_rd_outstanding !== 8'd0) begin n_fail++; $display("FAIL ret_no_wrap: got cnt=%0d want 0", b_rd_outstanding); end
    $display("test_read_return: two-beat return forwarded");
  endtask

  task automatic test_calib_block();
    do_reset();
    app_rdy = 1'b1; app_wdf_rdy = 1'b1;
    wr_req_valid = 1'b1; rd_req_valid = 1'b1;
    #1;
    n_checks++; if (a_wr_req_ready !== 1'b0 || a_rd_req_ready !== 1'b0) begin n_fail++; $display("FAIL calib_block: got %b%b want 00", a_wr_req_ready, a_rd_req_ready); end
    tick();
    n_checks++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL calib_busy: got %b want 0", a_busy); end
    init_calib_complete = 1'b1;
    #1;
    n_checks++; if (a_wr_req_ready !== 1'b1 || a_rd_req_ready !== 1'b0) begin n_fail++; $display("FAIL calib_release: got %b%b want 10", a_wr_req_ready, a_rd_req_ready); end
    wr_req_valid = 1'b0; rd_req_valid = 1'b0;
    $display("test_calib_block: grants blocked until calibration");
  endtask

  task automatic test_reset_mid_wr();
    logic [255:0] a_all;
    do_reset();
    init_calib_complete = 1'b1; app_rdy = 1'b1;
    rd_req_valid = 1'b1; rd_req_addr = 16'h0003;
    tick();
    rd_req_valid = 1'b0;
    tick();
    app_rdy = 1'b0; app_wdf_rdy = 1'b0;
    wr_req_valid = 1'b1; wr_req_addr = 16'h0020; wr_req_data = {64'h0, 64'h5555_AAAA_5555_AAAA};
    tick();
    wr_req_valid = 1'b0;
    tick();
    n_checks++; if (a_busy !== 1'b1 || a_app_en !== 1'b1 || a_rd_outstanding !== 8'd1) begin n_fail++; $display("FAIL midwr_pre: got busy=%b en=%b cnt=%0d want 1 1 1", a_busy, a_app_en, a_rd_outstanding); end
    rst = 1'b1;
    tick();
    a_all = {a_wr_req_ready, a_rd_req_ready, a_app_en, a_app_cmd, a_app_addr, a_app_wdf_data,
             a_app_wdf_wren, a_app_wdf_end, a_app_wdf_mask, a_app_burst, a_rd_data,
             a_rd_data_valid, a_rd_data_last, a_rd_outstanding, a_busy};
    n_checks++; if (a_all !== '0) begin n_fail++; $display("FAIL midwr_reset: got %h want 0", a_all); end
    rst = 1'b0;
    app_rdy = 1'b1; app_wdf_rdy = 1'b1;
    wr_req_valid = 1'b1; wr_req_addr = 16'h0001; wr_req_data = {64'h0, 64'h0000_0000_0000_00AB};
    #1;
    n_checks++; if (a_wr_req_ready !== 1'b1) begin n_fail++; $display("FAIL midwr_after_ready: got %b want 1", a_wr_req_ready); end
    tick();
    wr_req_valid = 1'b0;
    n_checks++; if (a_app_en !== 1'b1 || a_app_addr !== 28'h4 || a_app_wdf_data !== 64'hAB) begin n_fail++; $display("FAIL midwr_after_cmd: got en=%b addr=%h data=%h want 1 4 ab", a_app_en, a_app_addr, a_app_wdf_data); end
    tick();
    n_checks++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL midwr_after_idle: got %b want 0", a_busy); end
    $display("test_reset_mid_wr: reset abandoned write, next write completed");
  endtask

  initial begin
    test_reset();
    test_write_bl4();
    test_write_bl8_stall();
    test_round_robin();
    test_outstanding_limit();
    test_read_return();
    test_calib_block();
    test_reset_mid_wr();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
